// File: rtl/warp_fetch_unit.sv
// Per-warp PC file and round-robin fetch issue for one SM.
// Presents {warp, PC} to the instruction cache through a registered valid/ready port.
module warp_fetch_unit #(
    parameter int          NUM_WARPS   = 32'd4,
    parameter int          PC_WIDTH    = 32'd32,
    parameter int unsigned RESET_PC    = 32'd0,
    parameter int unsigned INSTR_BYTES = 32'd4,
    parameter int          WID_W       = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    input  logic [WID_W-1:0]     start_id,
    input  logic [PC_WIDTH-1:0]  start_pc,
    input  logic                 halt_valid,
    input  logic [WID_W-1:0]     halt_id,
    input  logic                 redirect_valid,
    input  logic [WID_W-1:0]     redirect_id,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    input  logic [NUM_WARPS-1:0] stall_mask,
    output logic                 ifetch_valid,
    input  logic                 ifetch_ready,
    output logic [WID_W-1:0]     ifetch_warp,
    output logic [PC_WIDTH-1:0]  ifetch_pc,
    output logic [NUM_WARPS-1:0] active_mask
);

    logic [PC_WIDTH-1:0]  pc_r        [NUM_WARPS];
    logic [PC_WIDTH-1:0]  pc_nxt_s    [NUM_WARPS];
    logic [NUM_WARPS-1:0] active_r;
    logic [NUM_WARPS-1:0] active_nxt_s;
    logic [WID_W-1:0]     rr_ptr_r;
    logic [WID_W-1:0]     rr_nxt_s;
    logic                 valid_r;
    logic                 valid_nxt_s;
    logic [WID_W-1:0]     warp_r;
    logic [WID_W-1:0]     warp_nxt_s;
    logic [PC_WIDTH-1:0]  pcout_r;
    logic [PC_WIDTH-1:0]  pcout_nxt_s;

    logic [NUM_WARPS-1:0] eligible_s;
    logic                 can_issue_s;
    logic                 any_s;
    logic                 issue_s;
    logic [WID_W-1:0]     grant_s;
    logic                 start_eff_s;

    // Warp index base+offs modulo NUM_WARPS (offs never exceeds NUM_WARPS).
    function automatic logic [WID_W-1:0] next_warp(input logic [WID_W-1:0] base, input int offs);
        int sum_v;
        sum_v = int'(base) + offs;
        if (sum_v >= NUM_WARPS) begin
            sum_v = sum_v - NUM_WARPS;
        end else begin
            sum_v = sum_v;
        end
        return sum_v[WID_W-1:0];
    endfunction

    assign can_issue_s = ~valid_r | ifetch_ready;
    assign issue_s     = can_issue_s & any_s;
    // A halt on the same warp cancels the launch entirely, PC included.
    assign start_eff_s = start_valid & ~(halt_valid & (halt_id == start_id));

    // Per-warp eligibility: active, not stalled, not being redirected this cycle.
    always_comb begin
        eligible_s = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible_s[w] = active_r[w] & ~stall_mask[w]
                          & ~(redirect_valid & (redirect_id == WID_W'(w)));
        end
    end

    // Round-robin search starting just after the last granted warp.
    always_comb begin
        grant_s = '0;
        any_s   = 1'b0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            grant_s = (!any_s && eligible_s[next_warp(rr_ptr_r, k)]) ? next_warp(rr_ptr_r, k) : grant_s;
            any_s   = any_s | eligible_s[next_warp(rr_ptr_r, k)];
        end
    end

    // Next-state for PCs, active bits and the output register.
    always_comb begin
        pc_nxt_s     = pc_r;
        active_nxt_s = active_r;
        rr_nxt_s     = rr_ptr_r;
        valid_nxt_s  = valid_r;
        warp_nxt_s   = warp_r;
        pcout_nxt_s  = pcout_r;

        if (issue_s) begin
            valid_nxt_s = 1'b1;
            warp_nxt_s  = grant_s;
            pcout_nxt_s = pc_r[grant_s];
            rr_nxt_s    = grant_s;
        end else if (can_issue_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end

        // Priority per warp: start > redirect > issue increment; halt > start.
        for (int w = 0; w < NUM_WARPS; w++) begin
            pc_nxt_s[w] = (start_eff_s && start_id == WID_W'(w))        ? start_pc :
                          (redirect_valid && redirect_id == WID_W'(w)) ? redirect_pc :
                          (issue_s && grant_s == WID_W'(w))            ? pc_r[w] + PC_WIDTH'(INSTR_BYTES) :
                                                                         pc_r[w];
            active_nxt_s[w] = (halt_valid && halt_id == WID_W'(w))   ? 1'b0 :
                              (start_eff_s && start_id == WID_W'(w)) ? 1'b1 :
                                                                       active_r[w];
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_r[w] <= PC_WIDTH'(RESET_PC);
            end
            active_r <= '0;
            rr_ptr_r <= WID_W'(NUM_WARPS - 1);
            valid_r  <= 1'b0;
            warp_r   <= '0;
            pcout_r  <= '0;
        end else begin
            pc_r     <= pc_nxt_s;
            active_r <= active_nxt_s;
            rr_ptr_r <= rr_nxt_s;
            valid_r  <= valid_nxt_s;
            warp_r   <= warp_nxt_s;
            pcout_r  <= pcout_nxt_s;
        end
    end

    assign ifetch_valid = valid_r;
    assign ifetch_warp  = warp_r;
    assign ifetch_pc    = pcout_r;
    assign active_mask  = active_r;

endmodule

// File: tb/tb_warp_fetch_unit.sv
// Self-checking bench for warp_fetch_unit: directed vector table, hand sequences,
// then randomized traffic against a behavioural model.
module tb_warp_fetch_unit;
    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid, halt_valid, redirect_valid, ifetch_ready;
    logic [1:0]  start_id, halt_id, redirect_id;
    logic [31:0] start_pc, redirect_pc;
    logic [3:0]  stall_mask;
    logic        ifetch_valid;
    logic [1:0]  ifetch_warp;
    logic [31:0] ifetch_pc;
    logic [3:0]  active_mask;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    warp_fetch_unit dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_id(start_id), .start_pc(start_pc),
        .halt_valid(halt_valid), .halt_id(halt_id),
        .redirect_valid(redirect_valid), .redirect_id(redirect_id), .redirect_pc(redirect_pc),
        .stall_mask(stall_mask),
        .ifetch_valid(ifetch_valid), .ifetch_ready(ifetch_ready),
        .ifetch_warp(ifetch_warp), .ifetch_pc(ifetch_pc),
        .active_mask(active_mask)
    );

    typedef struct {
        logic        sv;  logic [1:0] sid; logic [31:0] spc;
        logic        rv;  logic [1:0] rid; logic [31:0] rpc;
        logic [3:0]  stall; logic rdy;
        logic        ev;  logic [1:0] ew;  logic [31:0] ep; logic [3:0] ea;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic sv, input logic [1:0] sid, input logic [31:0] spc,
                       input logic rv, input logic [1:0] rid, input logic [31:0] rpc,
                       input logic [3:0] stall, input logic rdy,
                       input logic ev, input logic [1:0] ew, input logic [31:0] ep, input logic [3:0] ea);
        vec_t v;
        v.sv = sv; v.sid = sid; v.spc = spc; v.rv = rv; v.rid = rid; v.rpc = rpc;
        v.stall = stall; v.rdy = rdy; v.ev = ev; v.ew = ew; v.ep = ep; v.ea = ea;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_pulses();
        start_valid = 1'b0; halt_valid = 1'b0; redirect_valid = 1'b0; stall_mask = 4'h0;
    endtask

    // Clock one edge with the inputs currently driven, then check the outputs.
    task automatic step_expect(input string tag, input logic v, input logic [1:0] w,
                               input logic [31:0] p, input logic [3:0] act);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {31'd0, ifetch_valid}, {31'd0, v});
        if (v) begin
            chk({tag, ".warp"}, {30'd0, ifetch_warp}, {30'd0, w});
            chk({tag, ".pc"}, ifetch_pc, p);
        end
        chk({tag, ".active"}, {28'd0, active_mask}, {28'd0, act});
        clear_pulses();
    endtask

    // Behavioural reference: spec rules applied per cycle.
    logic [31:0] m_pc[NW];
    logic [3:0]  m_act;
    int          m_last;
    logic        m_v;
    int          m_w;
    logic [31:0] m_p;

    task automatic model_reset();
        for (int i = 0; i < NW; i++) m_pc[i] = 32'd0;
        m_act = 4'h0; m_last = NW - 1; m_v = 1'b0; m_w = 0; m_p = 32'd0;
    endtask

    task automatic model_step();
        int cand[$];
        if (!m_v || ifetch_ready) begin
            for (int k = 1; k <= NW; k++) begin
                int w = (m_last + k) % NW;
                if (m_act[w] && !stall_mask[w] && !(redirect_valid && int'(redirect_id) == w))
                    cand.push_back(w);
            end
            if (cand.size() > 0) begin
                m_v = 1'b1; m_w = cand[0]; m_p = m_pc[cand[0]];
                m_pc[cand[0]] = m_pc[cand[0]] + 32'd4;
                m_last = cand[0];
            end else begin
                m_v = 1'b0;
            end
        end
        if (redirect_valid) m_pc[redirect_id] = redirect_pc;
        if (start_valid && !(halt_valid && halt_id == start_id)) begin
            m_pc[start_id] = start_pc;
            m_act[start_id] = 1'b1;
        end
        if (halt_valid) m_act[halt_id] = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ifetch_ready = 1'b1;
        start_id = 2'd0; start_pc = 32'd0; halt_id = 2'd0; redirect_id = 2'd0; redirect_pc = 32'd0;
        clear_pulses();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", {31'd0, ifetch_valid}, 32'd0);
        chk("rst.warp", {30'd0, ifetch_warp}, 32'd0);
        chk("rst.pc", ifetch_pc, 32'd0);
        chk("rst.active", {28'd0, active_mask}, 32'd0);
        reset = 1'b0;

        // Launch, stream, ready-hold, stall mask, redirect.
        add(1,0,32'h100, 0,0,0, 4'h0,1, 0,0,32'h0,  4'h1);
        add(1,1,32'h200, 0,0,0, 4'h0,1, 1,0,32'h100,4'h3);
        add(1,2,32'h300, 0,0,0, 4'h0,1, 1,1,32'h200,4'h7);
        add(1,3,32'h400, 0,0,0, 4'h0,1, 1,2,32'h300,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,3,32'h400,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,0,32'h104,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,1,32'h204,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,2,32'h304,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,3,32'h404,4'hF);
        for (int i = 0; i < 5; i++)
            add(0,0,0,   0,0,0, 4'h0,0, 1,3,32'h404,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,0,32'h108,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,1,32'h208,4'hF);
        add(0,0,0,       0,0,0, 4'h2,1, 1,2,32'h308,4'hF);
        add(0,0,0,       0,0,0, 4'h2,1, 1,3,32'h408,4'hF);
        add(0,0,0,       0,0,0, 4'h2,1, 1,0,32'h10C,4'hF);
        add(0,0,0,       0,0,0, 4'h2,1, 1,2,32'h30C,4'hF);
        add(0,0,0,       0,0,0, 4'h2,1, 1,3,32'h40C,4'hF);
        add(0,0,0,       0,0,0, 4'h2,1, 1,0,32'h110,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,1,32'h20C,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,2,32'h310,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,3,32'h410,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,0,32'h114,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,1,32'h210,4'hF);
        add(0,0,0,       1,2,32'h800, 4'h0,1, 1,3,32'h414,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,0,32'h118,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,1,32'h214,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,2,32'h800,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,3,32'h418,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,0,32'h11C,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,1,32'h218,4'hF);
        add(0,0,0,       0,0,0, 4'h0,1, 1,2,32'h804,4'hF);

        foreach (vecs[i]) begin
            start_valid = vecs[i].sv; start_id = vecs[i].sid; start_pc = vecs[i].spc;
            redirect_valid = vecs[i].rv; redirect_id = vecs[i].rid; redirect_pc = vecs[i].rpc;
            stall_mask = vecs[i].stall; ifetch_ready = vecs[i].rdy;
            step_expect($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ew, vecs[i].ep, vecs[i].ea);
        end

        // Halt beats start on w1; start beats redirect on w3.
        ifetch_ready = 1'b1;
        start_valid = 1'b1; start_id = 2'd1; start_pc = 32'h1234; halt_valid = 1'b1; halt_id = 2'd1;
        step_expect("halt_start", 1'b1, 2'd3, 32'h41C, 4'hD);
        start_valid = 1'b1; start_id = 2'd3; start_pc = 32'h900;
        redirect_valid = 1'b1; redirect_id = 2'd3; redirect_pc = 32'hA00;
        step_expect("start_redir", 1'b1, 2'd0, 32'h120, 4'hD);
        step_expect("hs2", 1'b1, 2'd2, 32'h808, 4'hD);
        step_expect("hs3", 1'b1, 2'd3, 32'h900, 4'hD);
        step_expect("hs4", 1'b1, 2'd0, 32'h124, 4'hD);
        step_expect("hs5", 1'b1, 2'd2, 32'h80C, 4'hD);
        step_expect("hs6", 1'b1, 2'd3, 32'h904, 4'hD);

        // PC wrap at the top of the address space.
        start_valid = 1'b1; start_id = 2'd1; start_pc = 32'hFFFF_FFFC;
        step_expect("wrap0", 1'b1, 2'd0, 32'h128, 4'hF);
        step_expect("wrap1", 1'b1, 2'd1, 32'hFFFF_FFFC, 4'hF);
        step_expect("wrap2", 1'b1, 2'd2, 32'h810, 4'hF);
        step_expect("wrap3", 1'b1, 2'd3, 32'h908, 4'hF);
        step_expect("wrap4", 1'b1, 2'd0, 32'h12C, 4'hF);
        step_expect("wrap5", 1'b1, 2'd1, 32'h0, 4'hF);

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        reset = 1'b1;
        #2;
        chk("midrst.valid", {31'd0, ifetch_valid}, 32'd0);
        chk("midrst.active", {28'd0, active_mask}, 32'd0);
        chk("midrst.pc", ifetch_pc, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step_expect("postrst", 1'b0, 2'd0, 32'd0, 4'h0);

        // Randomized traffic against the model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            ifetch_ready   = ($urandom_range(0, 3) != 0);
            stall_mask     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            start_valid    = ($urandom_range(0, 5) == 0);
            start_id       = 2'($urandom);
            start_pc       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
            halt_valid     = ($urandom_range(0, 11) == 0);
            halt_id        = 2'($urandom);
            redirect_valid = ($urandom_range(0, 5) == 0);
            redirect_id    = 2'($urandom);
            redirect_pc    = $urandom;
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d.valid", c), {31'd0, ifetch_valid}, {31'd0, m_v});
            chk($sformatf("rnd%0d.active", c), {28'd0, active_mask}, {28'd0, m_act});
            if (m_v) begin
                chk($sformatf("rnd%0d.warp", c), {30'd0, ifetch_warp}, 32'(m_w));
                chk($sformatf("rnd%0d.pc", c), ifetch_pc, m_p);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/warp_fetch_unit.md
# warp_fetch_unit

Parametrised per-warp program-counter and fetch-issue unit for one SM. Holds one PC per warp, tracks which warps are active, selects one eligible warp per cycle by round-robin, and presents {warp id, PC} to the instruction cache through a registered valid/ready port. Supports warp launch, warp halt, per-warp stall masking and branch redirect.

## Interface
- NUM_WARPS, 4: warps per SM; ≥2. WID_W = $clog2(NUM_WARPS).
- PC_WIDTH, 32: PC width in bits.
- RESET_PC, 0: PC value loaded into every warp at reset.
- INSTR_BYTES, 4: PC increment per issued fetch.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start_valid  in  1  launch warp start_id at start_pc.
- start_id  in  WID_W  warp to launch.
- start_pc  in  PC_WIDTH  initial PC for the launched warp.
- halt_valid  in  1  deactivate warp halt_id.
- halt_id  in  WID_W  warp to halt.
- redirect_valid  in  1  branch redirect for warp redirect_id.
- redirect_id  in  WID_W  warp being redirected.
- redirect_pc  in  PC_WIDTH  branch target.
- stall_mask  in  NUM_WARPS  bit w=1 makes warp w ineligible this cycle.
- ifetch_valid  out  1  fetch request valid.
- ifetch_ready  in  1  cache accepts request.
- ifetch_warp  out  WID_W  warp of request.
- ifetch_pc  out  PC_WIDTH  PC of request.
- active_mask  out  NUM_WARPS  registered active-warp bits.

## Operation
- State: pc[w], active[w], rr_ptr (last granted warp), output register {ifetch_valid, ifetch_warp, ifetch_pc}.
- eligible[w] = active[w] & ~stall_mask[w] & ~(redirect_valid & redirect_id==w).
- can_issue = ~ifetch_valid | ifetch_ready.
- Arbiter: first eligible warp searching rr_ptr+1, rr_ptr+2, … modulo NUM_WARPS. On issue rr_ptr ← granted warp; otherwise unchanged.
- On issue (can_issue & |eligible): output register ← {1, g, pc[g]}; pc[g] ← pc[g]+INSTR_BYTES, wrapping modulo 2^PC_WIDTH.
- can_issue & no eligible warp: ifetch_valid ← 0. ~can_issue: output register holds, no PC changes from issue.
- Redirect: pc[redirect_id] ← redirect_pc; that warp cannot be granted in the same cycle. A request already held in the output register is not squashed; downstream discards stale fetches.
- Start: active[start_id] ← 1, pc[start_id] ← start_pc. Start overrides redirect on the same warp.
- Halt: active[halt_id] ← 0; PC unchanged. Halt overrides start on the same warp. A held request for the halted warp still completes.
- Issue, redirect, start and halt may target different warps in one cycle; all take effect.

## Timing
- Reset values: pc[*]=RESET_PC, active_mask=0, rr_ptr=NUM_WARPS-1 (warp 0 wins first), ifetch_valid=0, ifetch_warp=0, ifetch_pc=0.
- Start sampled at edge N → active_mask bit set after N → warp eligible in cycle N+1 → ifetch_valid high after edge N+1 (2-cycle launch-to-request).
- Throughput: one request per cycle while ifetch_ready=1 and a warp is eligible.
- Handshake: while ifetch_valid=1 & ifetch_ready=0, ifetch_warp/ifetch_pc stay stable; transfer on edge where both are high.
- Redirect at edge N: next request for that warp carries redirect_pc, earliest after edge N+1.
- Reset mid-operation: all state returns to reset values immediately; any held request is dropped.

## Test plan
- Reset, start warps 0–3 at 0x100/0x200/0x300/0x400 on one cycle each, ready=1 → requests w0@0x100, w1@0x200, w2@0x300, w3@0x400, w0@0x104, …; active_mask=0xF.
- Hold ready=0 for 5 cycles mid-stream → ifetch_warp/pc frozen, no PC advances; on release, order resumes with no skipped or duplicated warp.
- stall_mask=0b0010 with all active → grant order 0,2,3,0,2,3; clearing mask reinserts w1 at its round-robin position.
- Redirect w2 to 0x800 while w2 would be granted → w2 skipped that cycle; its next request is 0x800, then 0x804.
- Halt w1 simultaneously with start w1, and start w3 with redirect w3 (start_pc 0x900, redirect_pc 0xA00) → active[1]=0, w3 next fetches 0x900.
- Start a warp with PC_WIDTH-limited PC 2^PC_WIDTH−4 → requests at that value then 0x0; assert reset mid-stream → ifetch_valid=0 and active_mask=0 immediately.
